// File: rtl/captura_operandos.sv
// Operand capture front-end for a keypad-driven decimal add/subtract unit.
// Ports: clk, rst_n (sync, active-low), tecla_valida/tecla (key strobe/code),
//   c_in (adder result), a/b/oper (to adder), resultado/resultado_valido/
//   error (latched result and flags), visor (value to display).
module captura_operandos #(
    parameter int MAX_DIG = 4,
    parameter int LIMITE  = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tecla_valida,
    input  logic [3:0]  tecla,
    input  logic [13:0] c_in,
    output logic [13:0] a,
    output logic [13:0] b,
    output logic [1:0]  oper,
    output logic [13:0] resultado,
    output logic        resultado_valido,
    output logic        error,
    output logic [13:0] visor
);

    localparam int CW = $clog2(MAX_DIG + 1);

    typedef enum logic [1:0] {
        ESPERA_A,
        CAPTURA_B,
        CALCULA,
        MUESTRA
    } estado_t;

    estado_t estado;

    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;

    logic        es_digito;
    logic        es_oper;
    logic        es_igual;
    logic        es_borrar;
    logic [1:0]  oper_nuevo;
    logic [13:0] a_dig;
    logic [13:0] b_dig;
    logic [14:0] suma;
    logic        fuera;

    always_comb begin
        es_digito  = tecla_valida && (tecla <= 4'd9);
        es_oper    = tecla_valida && (tecla inside {4'hA, 4'hB, 4'hC});
        es_igual   = tecla_valida && (tecla == 4'hE);
        es_borrar  = tecla_valida && (tecla == 4'hF);
        oper_nuevo = 2'b00;
        unique case (tecla)
            4'hB:    oper_nuevo = 2'b01;
            4'hC:    oper_nuevo = 2'b10;
            default: oper_nuevo = 2'b00;
        endcase
    end

    // Decimal shift-in of the next digit.
    assign a_dig = a * 14'd10 + 14'(tecla);
    assign b_dig = b * 14'd10 + 14'(tecla);

    // Range check at 15 bits so a+b cannot wrap before comparison.
    assign suma  = {1'b0, a} + {1'b0, b};
    assign fuera = ((oper == 2'b00) && (suma > 15'(LIMITE)))
                || ((oper == 2'b01) && (b > a));

    always_ff @(posedge clk) begin
        if (!rst_n || es_borrar) begin
            estado    <= ESPERA_A;
            a         <= '0;
            b         <= '0;
            oper      <= 2'b00;
            resultado <= '0;
            error     <= 1'b0;
            cnt_a     <= '0;
            cnt_b     <= '0;
        end else begin
            unique case (estado)
                ESPERA_A: begin
                    if (es_digito && cnt_a < CW'(MAX_DIG)) begin
                        a     <= a_dig;
                        cnt_a <= cnt_a + 1'b1;
                    end else if (es_oper) begin
                        if (cnt_a == '0)
                            a <= '0;
                        oper   <= oper_nuevo;
                        b      <= '0;
                        cnt_b  <= '0;
                        estado <= CAPTURA_B;
                    end
                end
                CAPTURA_B: begin
                    if (es_digito && cnt_b < CW'(MAX_DIG)) begin
                        b     <= b_dig;
                        cnt_b <= cnt_b + 1'b1;
                    end else if (es_oper && cnt_b == '0) begin
                        oper <= oper_nuevo;
                    end else if (es_igual) begin
                        estado <= CALCULA;
                    end
                end
                CALCULA: begin
                    resultado <= c_in;
                    error     <= fuera;
                    estado    <= MUESTRA;
                end
                MUESTRA: begin
                    if (es_digito) begin
                        a      <= 14'(tecla);
                        b      <= '0;
                        cnt_a  <= CW'(1);
                        cnt_b  <= '0;
                        error  <= 1'b0;
                        estado <= ESPERA_A;
                    end else if (es_oper && !error) begin
                        // Chain the shown result as the next A operand.
                        a      <= resultado;
                        oper   <= oper_nuevo;
                        b      <= '0;
                        cnt_b  <= '0;
                        estado <= CAPTURA_B;
                    end
                end
                default: estado <= ESPERA_A;
            endcase
        end
    end

    assign resultado_valido = (estado == MUESTRA);

    always_comb begin
        visor = a;
        unique case (estado)
            CAPTURA_B: visor = b;
            MUESTRA:   visor = resultado;
            default:   visor = a;
        endcase
    end

endmodule

// File: doc/captura_operandos.md
CAPTURA_OPERANDOS -- requirements
Module: captura_operandos

Interface
REQ-001 Parameter MAX_DIG, default 4, maximum decimal digits accepted per operand.
REQ-002 Parameter LIMITE, default 9999, largest valid operand/result value.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 tecla_valida  input  1  one-cycle strobe; tecla is valid when high.
REQ-006 tecla  input  4  key code: 0x0-0x9 digit; 0xA SUM; 0xB RES; 0xC NO; 0xE equals; 0xF clear; 0xD/0xB..: 0xD ignored.
REQ-007 c_in  input  14  result returned by the downstream add/subtract unit.
REQ-008 a  output  14  registered operand A to the adder.
REQ-009 b  output  14  registered operand B to the adder.
REQ-010 oper  output  2  registered opcode: 00 SUM, 01 RES, 10 NO.
REQ-011 resultado  output  14  latched result.
REQ-012 resultado_valido  output  1  high while state is MUESTRA.
REQ-013 error  output  1  high while the latched result is out of range.
REQ-014 visor  output  14  value to display: operand being entered, or resultado in MUESTRA.

Function
REQ-015 FSM states SHALL be ESPERA_A, CAPTURA_B, CALCULA, MUESTRA; only strobed keys (tecla_valida=1) cause transitions, except CALCULA.
REQ-016 Digit entry SHALL compute operand <= operand*10 + digit, using a per-operand digit counter; digits beyond MAX_DIG SHALL be ignored, with no change.
REQ-017 ESPERA_A: digit updates a; operator key (0xA/0xB/0xC) loads oper, clears b and its digit count, goes to CAPTURA_B; equals ignored.
REQ-018 Operator key in ESPERA_A with no digits entered SHALL take a=0.
REQ-019 CAPTURA_B: digit updates b; operator key before any B digit replaces oper; operator key after B digits ignored; equals goes to CALCULA (b=0 if no digits).
REQ-020 a, b, oper SHALL be stable for the whole CALCULA cycle; CALCULA SHALL last exactly one cycle.
REQ-021 On the edge leaving CALCULA, resultado <= c_in, error <= range flag, state <= MUESTRA; total latency equals key to resultado_valido = 2 clocks.
REQ-022 Range flag SHALL be computed internally at 15 bits from a, b, oper: SUM and a+b > LIMITE; RES and b > a; NO never.
REQ-023 MUESTRA: digit clears a and b, loads a=digit (count 1), clears error, goes to ESPERA_A.
REQ-024 MUESTRA: operator key with error=0 SHALL chain: a <= resultado, oper loaded, b cleared, go to CAPTURA_B; with error=1 ignored.
REQ-025 MUESTRA: equals ignored; outputs held.
REQ-026 Clear (0xF) in any state SHALL apply reset values at the next edge.
REQ-027 Codes 0xD and tecla_valida=0 SHALL cause no state or output change.
REQ-028 visor SHALL be a in ESPERA_A, b in CAPTURA_B, a in CALCULA, resultado in MUESTRA.
REQ-029 All outputs SHALL be registered or decoded from registered state only; no combinational path from tecla to outputs.

Reset
REQ-030 When rst_n=0 at a rising edge, state <= ESPERA_A; a, b, resultado, visor <= 0; oper <= 00; error, resultado_valido <= 0; digit counts <= 0.
REQ-031 Reset SHALL take priority over any simultaneous key strobe and SHALL abort any state, including CALCULA, mid-operation.

Verification
REQ-032 Keys 1,2,SUM,3,4,equals (c_in from reference adder model) -> oper=00, a=12, b=34, 2 clocks after equals resultado=46, resultado_valido=1, error=0.
REQ-033 Keys 9,9,9,9,SUM,1,equals -> resultado=c_in (10000), error=1; later SUM key ignored, state stays MUESTRA.
REQ-034 Keys 5,RES,7,equals -> error=1, resultado=c_in (14'h3FFE).
REQ-035 Keys 1,2,3,4,5 in ESPERA_A -> a=1234, visor=1234; fifth digit ignored.
REQ-036 After 46 result, keys SUM,4,equals -> a=46, b=4, resultado=50; then digit 7 -> ESPERA_A, a=7, resultado_valido=0.
REQ-037 rst_n=0 during CAPTURA_B with b=56, simultaneous equals strobe -> next edge all outputs at reset values, state ESPERA_A.
